// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
//   Bundles the write, issue and read signals of the multi-port register file.
//   clk and rst_n stay outside as plain module ports.
//
//   Signals
//     wr0_en/wr0_addr/wr0_data   writeback port 0
//     wr1_en/wr1_addr/wr1_data   writeback port 1 (wins over port 0 on same address)
//     iss_en/iss_addr            issue: destination register gets a new producer
//     rd_addr                    packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//     rd_data                    packed combinational read data
//     rd_busy                    per read port: register has an outstanding producer
//     busy_cnt                   registered count of busy registers
//
//   Transfer semantics: there is no ready/backpressure. A write or issue is
//   accepted unconditionally on every rising clk edge where its enable is high
//   (and rst_n is high); reads are combinational and always valid.
//
//   Modports
//     master  decode/writeback side (drives enables, addresses, data)
//     slave   register file side
// -----------------------------------------------------------------------------
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output iss_en, iss_addr, rd_addr,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  iss_en, iss_addr, rd_addr,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Multi-port CPU register file with two write ports, NUM_RD combinational
//   read ports, optional same-cycle write-to-read forwarding and a per-register
//   busy scoreboard with a registered busy count.
//
//   Ports
//     clk    rising-edge clock, all state updates on posedge
//     rst_n  synchronous active-low reset (clears storage, busy bits, count)
//     bus    regfile_mp_if.slave: write ports, issue port, read ports, busy_cnt
//
//   Parameters
//     DATA_W    register width
//     ADDR_W    address width, DEPTH = 2**ADDR_W
//     NUM_RD    number of read ports (1..4)
//     ZERO_REG  1: register 0 reads as zero, ignores writes/issue, never busy
//     BYPASS    1: same-cycle write data/clear is visible on matching read ports
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [CNT_W-1:0]  busy_cnt_q;
  logic [CNT_W-1:0]  busy_cnt_nxt;

  logic w0_hit;
  logic w1_hit;
  logic iss_hit;
  logic w0_keep;

  // Effective hits: the zero register swallows writes and issues.
  always_comb begin
    w0_hit  = bus.wr0_en && !((ZERO_REG != 0) && (bus.wr0_addr == '0));
    w1_hit  = bus.wr1_en && !((ZERO_REG != 0) && (bus.wr1_addr == '0));
    iss_hit = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == '0));
    // Port 1 has priority: port 0 is dropped on an address collision.
    w0_keep = w0_hit && !(w1_hit && (bus.wr1_addr == bus.wr0_addr));
  end

  // Storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      if (w0_keep) begin
        regs[bus.wr0_addr] <= bus.wr0_data;
      end
      if (w1_hit) begin
        regs[bus.wr1_addr] <= bus.wr1_data;
      end
    end
  end

  // Scoreboard next state. An issue beats a retiring write on the same
  // register: the newly issued producer is the one still outstanding.
  always_comb begin
    busy_nxt     = busy;
    busy_cnt_nxt = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (iss_hit && (bus.iss_addr == ADDR_W'(r))) begin
        busy_nxt[r] = 1'b1;
      end else if ((w0_hit && (bus.wr0_addr == ADDR_W'(r))) ||
                   (w1_hit && (bus.wr1_addr == ADDR_W'(r)))) begin
        busy_nxt[r] = 1'b0;
      end
      busy_cnt_nxt = busy_cnt_nxt + CNT_W'(busy_nxt[r]);
    end
  end

  // The count is taken from busy_nxt so it lands on the same edge as the bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_cnt_q <= busy_cnt_nxt;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  // Read ports
  logic [DATA_W-1:0] port_data [NUM_RD];
  logic [NUM_RD-1:0] port_busy;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              fwd0;
    logic              fwd1;
    logic [DATA_W-1:0] d;

    assign a    = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign fwd1 = (BYPASS != 0) && w1_hit && (bus.wr1_addr == a);
    assign fwd0 = (BYPASS != 0) && w0_hit && (bus.wr0_addr == a);

    always_comb begin
      if ((ZERO_REG != 0) && (a == '0)) begin
        d = '0;
      end else if (fwd1) begin
        d = bus.wr1_data;
      end else if (fwd0) begin
        d = bus.wr0_data;
      end else begin
        d = regs[a];
      end
    end

    assign port_data[i] = d;
    // A retiring write on this register releases it already this cycle.
    assign port_busy[i] = busy[a] && !(fwd0 || fwd1);
  end

  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      bus.rd_data[i*DATA_W +: DATA_W] = port_data[i];
    end
  end

  assign bus.rd_busy = port_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Bench for regfile_mp. Two instances share one stimulus stream: dut with
//   forwarding enabled and dut_nb with forwarding disabled. Directed table
//   vectors cover forwarding, collisions, the zero register and the scoreboard;
//   a randomized phase compares both instances against a behavioural model.
// -----------------------------------------------------------------------------
module tb_regfile_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();
  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus_nb ();

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
               .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
               .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bus(bus_nb));

  assign bus_nb.wr0_en   = bus.wr0_en;
  assign bus_nb.wr0_addr = bus.wr0_addr;
  assign bus_nb.wr0_data = bus.wr0_data;
  assign bus_nb.wr1_en   = bus.wr1_en;
  assign bus_nb.wr1_addr = bus.wr1_addr;
  assign bus_nb.wr1_data = bus.wr1_data;
  assign bus_nb.iss_en   = bus.iss_en;
  assign bus_nb.iss_addr = bus.iss_addr;
  assign bus_nb.rd_addr  = bus.rd_addr;

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_regs [DEPTH];
  bit                m_busy [DEPTH];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_rd(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && bus.wr1_en && (int'(bus.wr1_addr) == a)) return bus.wr1_data;
    if (byp && bus.wr0_en && (int'(bus.wr0_addr) == a)) return bus.wr0_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int a, input bit byp);
    if (!m_busy[a]) return 1'b0;
    if (byp && ((bus.wr0_en && int'(bus.wr0_addr) == a) ||
                (bus.wr1_en && int'(bus.wr1_addr) == a))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int r = 0; r < DEPTH; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  // Apply one clock edge to the model; later statements win, so wr1 overrides
  // wr0 and an issue overrides a clear.
  task automatic model_edge();
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (bus.wr0_en && bus.wr0_addr != 0) begin
        m_regs[bus.wr0_addr] = bus.wr0_data;
        m_busy[bus.wr0_addr] = 1'b0;
      end
      if (bus.wr1_en && bus.wr1_addr != 0) begin
        m_regs[bus.wr1_addr] = bus.wr1_data;
        m_busy[bus.wr1_addr] = 1'b0;
      end
      if (bus.iss_en && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < NUM_RD; i++) begin
      int a;
      a = int'(bus.rd_addr[i*ADDR_W +: ADDR_W]);
      check($sformatf("rand_rd_data%0d", i), 64'(bus.rd_data[i*DATA_W +: DATA_W]), 64'(exp_rd(a, 1'b1)));
      check($sformatf("rand_rd_busy%0d", i), 64'(bus.rd_busy[i]), 64'(exp_busy(a, 1'b1)));
      check($sformatf("rand_nb_rd_data%0d", i), 64'(bus_nb.rd_data[i*DATA_W +: DATA_W]), 64'(exp_rd(a, 1'b0)));
      check($sformatf("rand_nb_rd_busy%0d", i), 64'(bus_nb.rd_busy[i]), 64'(exp_busy(a, 1'b0)));
    end
    check("rand_busy_cnt", 64'(bus.busy_cnt), 64'(exp_cnt()));
    check("rand_nb_busy_cnt", 64'(bus_nb.busy_cnt), 64'(exp_cnt()));
  endtask

  // Inputs are set on the falling edge; outputs sampled 1 time unit later.
  task automatic step(input bit use_model);
    #1;
    if (use_model) check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
    bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
    bus.iss_en = 1'b0; bus.iss_addr = '0;
    bus.rd_addr = '0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    // Bias toward a few low registers so collisions and bypasses are common.
    if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, DEPTH-1));
    return ADDR_W'($urandom_range(0, 7));
  endfunction

  task automatic drive_random();
    bus.wr0_en   = 1'($urandom_range(0, 1));
    bus.wr0_addr = rand_addr();
    bus.wr0_data = $urandom;
    bus.wr1_en   = 1'($urandom_range(0, 1));
    bus.wr1_addr = rand_addr();
    bus.wr1_data = $urandom;
    bus.iss_en   = 1'($urandom_range(0, 1));
    bus.iss_addr = rand_addr();
    for (int i = 0; i < NUM_RD; i++) bus.rd_addr[i*ADDR_W +: ADDR_W] = rand_addr();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit                w0e;
    logic [ADDR_W-1:0] w0a;
    logic [DATA_W-1:0] w0d;
    bit                w1e;
    logic [ADDR_W-1:0] w1a;
    logic [DATA_W-1:0] w1d;
    bit                ie;
    logic [ADDR_W-1:0] ia;
    logic [ADDR_W-1:0] r0;
    logic [ADDR_W-1:0] r1;
    logic [DATA_W-1:0] e_rd0;
    logic [DATA_W-1:0] e_rd1;
    logic [1:0]        e_busy;
    logic [ADDR_W:0]   e_cnt;
    logic [DATA_W-1:0] e_nb_rd0;
    logic [1:0]        e_nb_busy;
  } vec_t;

  function automatic vec_t mk(
    input bit w0e, input int w0a, input logic [DATA_W-1:0] w0d,
    input bit w1e, input int w1a, input logic [DATA_W-1:0] w1d,
    input bit ie, input int ia, input int r0, input int r1,
    input logic [DATA_W-1:0] e_rd0, input logic [DATA_W-1:0] e_rd1,
    input int e_busy, input int e_cnt,
    input logic [DATA_W-1:0] e_nb_rd0, input int e_nb_busy);
    vec_t v;
    v.w0e = w0e; v.w0a = ADDR_W'(w0a); v.w0d = w0d;
    v.w1e = w1e; v.w1a = ADDR_W'(w1a); v.w1d = w1d;
    v.ie = ie; v.ia = ADDR_W'(ia);
    v.r0 = ADDR_W'(r0); v.r1 = ADDR_W'(r1);
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
    v.e_busy = 2'(e_busy); v.e_cnt = (ADDR_W+1)'(e_cnt);
    v.e_nb_rd0 = e_nb_rd0; v.e_nb_busy = 2'(e_nb_busy);
    return v;
  endfunction

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  // ---------------- main sequence ----------------
  initial begin
    //           w0e w0a w0d         w1e w1a w1d            ie ia r0 r1  e_rd0       e_rd1      bsy cnt nb_rd0     nb_bsy
    vecs[0]  = mk(0, 0, 32'h0,       0, 0, 32'h0,           0, 0, 0, 0,  32'h0,      32'h0,     0,  0, 32'h0,     0);
    vecs[1]  = mk(1, 5, 32'h1234,    0, 0, 32'h0,           0, 0, 5, 0,  32'h1234,   32'h0,     0,  0, 32'h0,     0);
    vecs[2]  = mk(0, 0, 32'h0,       0, 0, 32'h0,           0, 0, 5, 0,  32'h1234,   32'h0,     0,  0, 32'h1234,  0);
    vecs[3]  = mk(1, 7, 32'hAAAA,    1, 7, 32'h5555,        0, 0, 7, 5,  32'h5555,   32'h1234,  0,  0, 32'h0,     0);
    vecs[4]  = mk(0, 0, 32'h0,       0, 0, 32'h0,           0, 0, 7, 7,  32'h5555,   32'h5555,  0,  0, 32'h5555,  0);
    vecs[5]  = mk(0, 0, 32'h0,       1, 0, 32'hFFFF_FFFF,   1, 0, 0, 0,  32'h0,      32'h0,     0,  0, 32'h0,     0);
    vecs[6]  = mk(0, 0, 32'h0,       0, 0, 32'h0,           0, 0, 0, 0,  32'h0,      32'h0,     0,  0, 32'h0,     0);
    vecs[7]  = mk(0, 0, 32'h0,       0, 0, 32'h0,           1, 3, 3, 3,  32'h0,      32'h0,     0,  0, 32'h0,     0);
    vecs[8]  = mk(0, 0, 32'h0,       0, 0, 32'h0,           0, 0, 3, 5,  32'h0,      32'h1234,  1,  1, 32'h0,     1);
    vecs[9]  = mk(1, 3, 32'hBEEF,    0, 0, 32'h0,           0, 0, 3, 3,  32'hBEEF,   32'hBEEF,  0,  1, 32'h0,     3);
    vecs[10] = mk(0, 0, 32'h0,       0, 0, 32'h0,           0, 0, 3, 3,  32'hBEEF,   32'hBEEF,  0,  0, 32'hBEEF,  0);
    vecs[11] = mk(0, 0, 32'h0,       1, 3, 32'hCAFE,        1, 3, 3, 4,  32'hCAFE,   32'h0,     0,  0, 32'hBEEF,  0);
    vecs[12] = mk(0, 0, 32'h0,       0, 0, 32'h0,           0, 0, 3, 4,  32'hCAFE,   32'h0,     1,  1, 32'hCAFE,  1);
    vecs[13] = mk(0, 0, 32'h0,       0, 0, 32'h0,           1, 3, 3, 3,  32'hCAFE,   32'hCAFE,  3,  1, 32'hCAFE,  3);
    vecs[14] = mk(0, 0, 32'h0,       0, 0, 32'h0,           1, 9, 3, 9,  32'hCAFE,   32'h0,     1,  1, 32'hCAFE,  1);
    vecs[15] = mk(1, 3, 32'h1111,    1, 9, 32'h2222,        1, 3, 3, 9,  32'h1111,   32'h2222,  0,  2, 32'hCAFE,  3);
    vecs[16] = mk(0, 0, 32'h0,       0, 0, 32'h0,           0, 0, 3, 9,  32'h1111,   32'h2222,  1,  1, 32'h1111,  1);

    // Reset with idle inputs.
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    step(1'b0);
    #1;
    check("reset_busy_cnt", 64'(bus.busy_cnt), 64'd0);
    check("reset_nb_busy_cnt", 64'(bus_nb.busy_cnt), 64'd0);
    rst_n = 1'b1;

    // Random warm-up, then a reset edge with writes and issues still active.
    for (int c = 0; c < 40; c++) begin
      drive_random();
      step(1'b1);
    end
    drive_random();
    bus.iss_en = 1'b1;
    bus.wr0_en = 1'b1;
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
    drive_idle();
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr[0 +: ADDR_W]      = ADDR_W'(a);
      bus.rd_addr[ADDR_W +: ADDR_W] = ADDR_W'(DEPTH - 1 - a);
      #1;
      check($sformatf("post_reset_rd_data_r%0d", a), 64'(bus.rd_data), 64'd0);
      check($sformatf("post_reset_rd_busy_r%0d", a), 64'(bus.rd_busy), 64'd0);
      check("post_reset_busy_cnt", 64'(bus.busy_cnt), 64'd0);
      @(negedge clk);
    end

    // Directed table.
    for (int k = 0; k < NVEC; k++) begin
      bus.wr0_en = vecs[k].w0e; bus.wr0_addr = vecs[k].w0a; bus.wr0_data = vecs[k].w0d;
      bus.wr1_en = vecs[k].w1e; bus.wr1_addr = vecs[k].w1a; bus.wr1_data = vecs[k].w1d;
      bus.iss_en = vecs[k].ie;  bus.iss_addr = vecs[k].ia;
      bus.rd_addr[0 +: ADDR_W]      = vecs[k].r0;
      bus.rd_addr[ADDR_W +: ADDR_W] = vecs[k].r1;
      #1;
      check($sformatf("vec%0d_rd_data0", k), 64'(bus.rd_data[0 +: DATA_W]), 64'(vecs[k].e_rd0));
      check($sformatf("vec%0d_rd_data1", k), 64'(bus.rd_data[DATA_W +: DATA_W]), 64'(vecs[k].e_rd1));
      check($sformatf("vec%0d_rd_busy", k), 64'(bus.rd_busy), 64'(vecs[k].e_busy));
      check($sformatf("vec%0d_busy_cnt", k), 64'(bus.busy_cnt), 64'(vecs[k].e_cnt));
      check($sformatf("vec%0d_nb_rd_data0", k), 64'(bus_nb.rd_data[0 +: DATA_W]), 64'(vecs[k].e_nb_rd0));
      check($sformatf("vec%0d_nb_rd_busy", k), 64'(bus_nb.rd_busy), 64'(vecs[k].e_nb_busy));
      step(1'b0);
    end

    // Randomized phase with occasional mid-run resets.
    drive_idle();
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      drive_random();
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      step(1'b1);
    end
    rst_n = 1'b1;
    drive_idle();
    step(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
